lc3_regfile_mp: RTL
===================

LC3_REGFILE_MP -- requirements
Module: lc3_regfile_mp

Interface
REQ-001 The block SHALL use parameter DATA_W, default 16, as the register width in bits.
REQ-002 The block SHALL use parameter NUM_REGS, default 8, as the register count (power of two, at least 2); ADDR_W SHALL be derived as $clog2(NUM_REGS).
REQ-003 The block SHALL use parameter BYPASS, default 1, where 1 enables write-to-read forwarding.
REQ-004 The block SHALL have clock, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 The block SHALL have reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have wr / dr / din, inputs of 1 / ADDR_W / DATA_W bits: write enable, destination index, write data.
REQ-007 The block SHALL have setcc, input, 1 bit: update nzp from din when a write is accepted.
REQ-008 The block SHALL have sr1 / sr2, inputs of ADDR_W bits each: read indices.
REQ-009 The block SHALL have d1 / d2, outputs of DATA_W bits each: read data.
REQ-010 The block SHALL have lock / lock_dr, inputs of 1 / ADDR_W bits: mark a register pending (issued, result not yet written).
REQ-011 The block SHALL have busy1 / busy2, outputs of 1 bit each: the sr1 / sr2 register is pending.
REQ-012 The block SHALL have nzp, output, 3 bits: condition codes {N,Z,P}.
REQ-013 The block SHALL have clr_req, input, 1 bit: request a zero-fill of all registers.
REQ-014 The block SHALL have ready, output, 1 bit: 1 when the file is usable (the FSM is in RUN).

Function
REQ-015 The FSM SHALL have two states, CLEAR and RUN; reset SHALL enter CLEAR.
REQ-016 In CLEAR, an index counter starting at 0 SHALL write zero to one register per cycle; after index NUM_REGS-1 is written, the next state SHALL be RUN, so ready rises exactly NUM_REGS cycles after reset release.
REQ-017 clr_req=1 in RUN SHALL move the FSM to CLEAR on the next edge with the counter at 0; clr_req in CLEAR SHALL be ignored and SHALL NOT restart the count.
REQ-018 Entering CLEAR SHALL clear all pending bits and set nzp to 3'b010.
REQ-019 While in CLEAR, wr, lock and setcc SHALL be ignored, and d1, d2, busy1 and busy2 SHALL be driven to 0.
REQ-020 In RUN, wr=1 SHALL write din to ram[dr] on the rising edge; with wr=0, storage SHALL hold.
REQ-021 Reads SHALL be combinational, with d1=ram[sr1] and d2=ram[sr2].
REQ-022 With BYPASS=1, if wr=1 and dr==srN in the same cycle, dN SHALL equal din; with BYPASS=0, dN SHALL show the old value until the edge.
REQ-023 In RUN, lock=1 SHALL set pending[lock_dr] on the next edge, and an accepted write SHALL clear pending[dr].
REQ-024 If lock and wr target the same index in one cycle, the set SHALL win and the bit SHALL end at 1.
REQ-025 busyN SHALL equal pending[srN] AND NOT (BYPASS AND wr AND dr==srN).
REQ-026 On an accepted write with setcc=1, nzp SHALL become N=din[DATA_W-1], Z=(din==0), P=!N&&!Z, visible the cycle after the edge; setcc with wr=0 SHALL have no effect.
REQ-027 Exactly one nzp bit SHALL be set at all times.

Reset
REQ-028 reset_n=0 SHALL asynchronously force state=CLEAR, counter=0, pending=all 0, nzp=3'b010 and ready=0.
REQ-029 Register storage SHALL have no reset and SHALL be zeroed only by the CLEAR sequence.
REQ-030 Reset asserted mid-CLEAR or mid-RUN SHALL restart the full CLEAR sequence after release.

Structure
REQ-031 Package lc3_rf_pkg SHALL hold the state enum (CLEAR, RUN), the nzp bit-position constants, and the DATA_W/NUM_REGS defaults.
REQ-032 The pending-bit vector, its set/clear priority and the busy generation SHALL live in sub-module lc3_rf_scoreboard, parametrised by NUM_REGS.

Verification
REQ-033 Scenario: release reset with defaults -> ready=0 for 8 cycles, then 1; all registers read 0; nzp=010.
REQ-034 Scenario: write R3=16'h8001 with setcc=1, then read sr1=3 -> d1=16'h8001 and nzp=100; a following write of 0 with setcc=1 -> nzp=010.
REQ-035 Scenario: in one cycle, wr=1, dr=5, din=16'h1234, sr2=5 -> d2=16'h1234 combinationally with BYPASS=1, and the old value with BYPASS=0.
REQ-036 Scenario: lock R2, next cycle sr1=2 -> busy1=1; write R2 -> busy1=0 the same cycle with BYPASS=1, and the cycle after with BYPASS=0; lock and write R4 in the same cycle -> pending[4]=1.
REQ-037 Scenario: clr_req after R1..R7 are filled -> ready=0 for 8 cycles, wr and lock ignored, all registers 0; clr_req pulsed again mid-clear -> still exactly 8 cycles.
REQ-038 Scenario: assert reset_n=0 mid-CLEAR at counter=4 -> ready=0 immediately; after release, a full 8-cycle clear; also run with NUM_REGS=16, DATA_W=32 -> 16-cycle clear.

Source files
------------

// File: rtl/lc3_rf_pkg.sv
// Shared types and constants for the LC-3 style multi-port register file.
// Holds the FSM state enum, nzp bit positions and parameter defaults.
package lc3_rf_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 8;

  localparam int NZP_N = 2;
  localparam int NZP_Z = 1;
  localparam int NZP_P = 0;
  localparam logic [2:0] NZP_CLEAR = 3'b010;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/lc3_rf_scoreboard.sv
// Pending-result bits for each register and the busy flags derived from them.
// A lock (issue) beats a write (retire) aimed at the same index in one cycle.
module lc3_rf_scoreboard #(
  parameter int  NUM_REGS = 8,
  parameter bit  BYPASS   = 1'b1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              lock,
  input  logic [ADDR_W-1:0] lock_dr,
  input  logic              wr,
  input  logic [ADDR_W-1:0] dr,
  input  logic [ADDR_W-1:0] sr1,
  input  logic [ADDR_W-1:0] sr2,
  output logic              busy1,
  output logic              busy2
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;

  always_comb begin
    pending_nxt = pending;
    if (wr)   pending_nxt[dr]      = 1'b0;
    if (lock) pending_nxt[lock_dr] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   pending <= '0;
    else if (flush) pending <= '0;
    else            pending <= pending_nxt;
  end

  // A write landing this cycle resolves the hazard early when forwarding is on.
  assign busy1 = pending[sr1] & ~(BYPASS & wr & (dr == sr1));
  assign busy2 = pending[sr2] & ~(BYPASS & wr & (dr == sr2));

endmodule

// File: rtl/lc3_regfile_mp.sv
// Two-read/one-write register file with condition codes, pending-result tracking
// and a sequential zero-fill (CLEAR) that runs after reset or on request.
module lc3_regfile_mp
  import lc3_rf_pkg::*;
#(
  parameter int  DATA_W   = DEF_DATA_W,
  parameter int  NUM_REGS = DEF_NUM_REGS,
  parameter bit  BYPASS   = 1'b1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr,
  input  logic [ADDR_W-1:0] dr,
  input  logic [DATA_W-1:0] din,
  input  logic              setcc,
  input  logic [ADDR_W-1:0] sr1,
  input  logic [ADDR_W-1:0] sr2,
  output logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] d2,
  input  logic              lock,
  input  logic [ADDR_W-1:0] lock_dr,
  output logic              busy1,
  output logic              busy2,
  output logic [2:0]        nzp,
  input  logic              clr_req,
  output logic              ready,
  output rf_state_e         fsm_state
);

  logic [DATA_W-1:0] ram [NUM_REGS];
  rf_state_e         state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              run, wr_ok, lock_ok, flush;
  logic              sb_busy1, sb_busy2;

  function automatic logic [2:0] cc_of(input logic [DATA_W-1:0] v);
    logic [2:0] cc;
    cc        = '0;
    cc[NZP_N] = v[DATA_W-1];
    cc[NZP_Z] = (v == '0);
    cc[NZP_P] = ~v[DATA_W-1] & (v != '0);
    return cc;
  endfunction

  assign run     = (state == RUN);
  assign wr_ok   = run & wr;
  assign lock_ok = run & lock;
  // Pending bits and nzp are reset on the edge into CLEAR and held there.
  assign flush   = ~run | clr_req;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        cnt_nxt = cnt + ADDR_W'(1);
        if (cnt == ADDR_W'(NUM_REGS - 1)) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Storage is deliberately unreset; only the CLEAR walk zeroes it.
  always_ff @(posedge clock) begin
    if (!run)       ram[cnt] <= '0;
    else if (wr_ok) ram[dr]  <= din;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)            nzp <= NZP_CLEAR;
    else if (flush)          nzp <= NZP_CLEAR;
    else if (wr_ok && setcc) nzp <= cc_of(din);
  end

  assign d1 = !run ? '0 : ((BYPASS && wr && (dr == sr1)) ? din : ram[sr1]);
  assign d2 = !run ? '0 : ((BYPASS && wr && (dr == sr2)) ? din : ram[sr2]);

  lc3_rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .lock    (lock_ok),
    .lock_dr (lock_dr),
    .wr      (wr_ok),
    .dr      (dr),
    .sr1     (sr1),
    .sr2     (sr2),
    .busy1   (sb_busy1),
    .busy2   (sb_busy2)
  );

  assign busy1     = run & sb_busy1;
  assign busy2     = run & sb_busy2;
  assign ready     = run;
  assign fsm_state = state;

endmodule
